// File: rtl/burst_ram_sram_bridge.sv
// Responder for the burst RAM command interface, mapped onto a synchronous
// single-port SRAM with 1-cycle read latency and BurstRAM-compatible read timing.
module burst_ram_sram_bridge #(
    parameter int DATA_BITWIDTH            = 64,
    parameter int DEPTH_BITWIDTH           = 8,
    parameter int BURST_COUNT              = 4,
    parameter int CYCLES_BEFORE_DATA_READY = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd,
    input  logic                          cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]     addr,
    input  logic [DATA_BITWIDTH-1:0]      wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]    data_mask,
    output logic [DATA_BITWIDTH-1:0]      rd_data,
    output logic                          rd_data_valid,
    output logic                          busy,
    output logic                          err,
    output logic                          sram_en,
    output logic [DATA_BITWIDTH/8-1:0]    sram_we,
    output logic [DEPTH_BITWIDTH-1:0]     sram_addr,
    output logic [DATA_BITWIDTH-1:0]      sram_wdata,
    input  logic [DATA_BITWIDTH-1:0]      sram_rdata
);

    localparam int BEAT_W = $clog2(BURST_COUNT + 1);
    localparam int WAIT_W = $clog2(CYCLES_BEFORE_DATA_READY + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT);
    // RD_WAIT is left on the edge L-2 after acceptance; the counter starts at 0 on acceptance.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CYCLES_BEFORE_DATA_READY - 3);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_ISSUE,
        RD_DRAIN,
        WR
    } state_t;

    state_t                    state;
    logic [BEAT_W-1:0]         beat;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [DEPTH_BITWIDTH-1:0] base_addr;
    logic                      rd_pend;

    // NOTE: every register here, outputs included, is updated with non-blocking
    // assignments so all of them see pre-edge values of each other within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= '0;
            wait_cnt      <= '0;
            base_addr     <= '0;
            rd_pend       <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            sram_en       <= 1'b0;
            sram_we       <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
        end else begin
            // Read return pipeline: SRAM answers one cycle after the access, then rd_data registers it.
            rd_pend       <= (state == RD_ISSUE);
            rd_data_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= sram_rdata;
            end

            if (cmd_en && busy) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_en) begin
                        busy <= 1'b1;
                        beat <= BEAT_W'(1);
                        if (cmd) begin
                            state      <= WR;
                            sram_en    <= 1'b1;
                            sram_we    <= ~data_mask;
                            sram_addr  <= addr;
                            sram_wdata <= wr_data;
                        end else if (CYCLES_BEFORE_DATA_READY == 2) begin
                            state     <= RD_ISSUE;
                            sram_en   <= 1'b1;
                            sram_we   <= '0;
                            sram_addr <= addr;
                        end else begin
                            state     <= RD_WAIT;
                            base_addr <= addr;
                            wait_cnt  <= '0;
                        end
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state     <= RD_ISSUE;
                        sram_en   <= 1'b1;
                        sram_we   <= '0;
                        sram_addr <= base_addr;
                        beat      <= BEAT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                RD_ISSUE: begin
                    if (beat == BEAT_LAST) begin
                        state   <= RD_DRAIN;
                        sram_en <= 1'b0;
                    end else begin
                        sram_addr <= sram_addr + DEPTH_BITWIDTH'(1);
                        beat      <= beat + BEAT_W'(1);
                    end
                end

                RD_DRAIN: begin
                    // Last beat is on rd_data now and nothing is left in flight.
                    if (rd_data_valid && !rd_pend) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                WR: begin
                    if (beat == BEAT_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        sram_en <= 1'b0;
                        sram_we <= '0;
                    end else begin
                        sram_we    <= ~data_mask;
                        sram_addr  <= sram_addr + DEPTH_BITWIDTH'(1);
                        sram_wdata <= wr_data;
                        beat       <= beat + BEAT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sram_en <= 1'b0;
                    sram_we <= '0;
                end
            endcase
        end
    end

endmodule
